// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter: drains a synchronous FIFO onto a valid/ready stream.
// Absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer and
// only issues reads when the buffer is guaranteed to have room. The buffer
// has room when the occupied entries plus the word in flight, minus the word
// leaving this cycle, is below 2. A FIFO underflow observed on an in-flight
// read is recorded in a sticky error flag.
module fifo_rd_adapter #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_almostempty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [15:0]           rd_count,
  output logic                  underflow_err,
  input  logic                  clear_err
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  in_flight_q, in_flight_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic                  err_q, err_d;

  logic                  pop;
  logic                  capture;
  logic                  uf_hit;
  logic [2:0]            pending;

  // Stream handshake and read-request decision.
  always_comb begin
    m_valid    = (occ_q != OCC_EMPTY);
    m_data     = head_q ? buf1_q : buf0_q;
    pop        = m_valid && m_ready;
    capture    = in_flight_q && !fifo_underflow;
    uf_hit     = in_flight_q && fifo_underflow;
    // Entries that will be committed after this cycle, counting the word
    // already on its way from the FIFO.
    pending    = 3'(occ_q) + {2'b00, in_flight_q} - {2'b00, pop};
    // The almost-empty term stops a second read while the FIFO's last word
    // is in flight: its empty flag lags by one cycle.
    fifo_rd_en = !fifo_empty
                 && !(in_flight_q && fifo_almostempty)
                 && (pending < 3'd2);
  end

  // Occupancy FSM: EMPTY / ONE / TWO driven by capture and pop.
  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (capture) begin
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (capture && !pop) begin
          occ_d = OCC_TWO;
        end else if (!capture && pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // A capture into a full buffer without a pop is excluded by the
        // read gating, so only the pop-only case changes state here.
        if (pop && !capture) begin
          occ_d = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Buffer storage, pointers, pop counter and sticky error next-state.
  always_comb begin
    in_flight_d = fifo_rd_en;
    head_d      = head_q ^ pop;
    tail_d      = tail_q ^ capture;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    if (capture && !tail_q) begin
      buf0_d = fifo_data_out;
    end
    if (capture && tail_q) begin
      buf1_d = fifo_data_out;
    end
    rd_count_d = rd_count_q + 16'(pop);
    err_d      = err_q;
    if (clear_err) begin
      err_d = 1'b0;
    end
    // A fresh underflow wins over a simultaneous clear.
    if (uf_hit) begin
      err_d = 1'b1;
    end
  end

  // State registers; reset drops any in-flight word and empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      in_flight_q <= 1'b0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      rd_count_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      rd_count_q  <= rd_count_d;
      err_q       <= err_d;
    end
  end

  assign rd_count      = rd_count_q;
  assign underflow_err = err_q;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter, driving it from a small synchronous
// FIFO model whose empty/almost-empty flags lag the contents by one cycle.
module tb_fifo_rd_adapter;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty, fifo_almostempty, fifo_underflow;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic [15:0]   rd_count;
  logic          underflow_err;
  logic          clear_err = 1'b0;

  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          force_uf = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_adapter #(.FIFO_WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_empty       (fifo_empty),
    .fifo_almostempty (fifo_almostempty),
    .fifo_underflow   (fifo_underflow),
    .fifo_data_out    (fifo_data_out),
    .fifo_rd_en       (fifo_rd_en),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .rd_count         (rd_count),
    .underflow_err    (underflow_err),
    .clear_err        (clear_err)
  );

  // FIFO model
  logic [W-1:0] fmem [0:127];
  int           fcnt, frp, fwp;
  logic         empty_q, ae_q, fuf_q;
  logic [W-1:0] fdout_q;
  logic         f_rd;

  assign f_rd             = fifo_rd_en && (fcnt != 0);
  assign fifo_empty       = empty_q;
  assign fifo_almostempty = ae_q;
  assign fifo_underflow   = fuf_q | force_uf;
  assign fifo_data_out    = fdout_q;

  always @(posedge clk) begin
    if (wr_en) fmem[fwp] <= wr_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt    <= 0;
      frp     <= 0;
      fwp     <= 0;
      empty_q <= 1'b1;
      ae_q    <= 1'b0;
      fuf_q   <= 1'b0;
      fdout_q <= '0;
    end else begin
      empty_q <= (fcnt == 0);
      ae_q    <= (fcnt == 1);
      fuf_q   <= fifo_rd_en && (fcnt == 0);
      if (f_rd) begin
        fdout_q <= fmem[frp];
        frp     <= (frp + 1) % 128;
      end
      if (wr_en) fwp <= (fwp + 1) % 128;
      fcnt <= fcnt + (wr_en ? 1 : 0) - (f_rd ? 1 : 0);
    end
  end

  // Scoreboard and event counters
  logic [W-1:0] exp_q[$];
  int pops = 0, rden_cnt = 0, uf_cnt = 0, sb_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          sb_err <= sb_err + 1;
        end else begin
          if (exp_q[0] !== m_data) sb_err <= sb_err + 1;
          void'(exp_q.pop_front());
        end
        pops <= pops + 1;
      end
      if (wr_en) exp_q.push_back(wr_data);
      rden_cnt <= rden_cnt + (fifo_rd_en ? 1 : 0);
      uf_cnt   <= uf_cnt + (fifo_underflow ? 1 : 0);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en     = 1'b0;
    m_ready   = 1'b0;
    clear_err = 1'b0;
    force_uf  = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_pops(input int target, input int limit, input string tag);
    int k = 0;
    while (pops < target && k < limit) begin
      step();
      k++;
    end
    chk(tag, pops, target);
  endtask

  task automatic wait_rden(input int limit, input string tag);
    int k = 0;
    while (!fifo_rd_en && k < limit) begin
      step();
      k++;
    end
    chk(tag, fifo_rd_en, 1);
  endtask

  initial begin
    int base, base_rd, base_uf, k;

    // Reset state
    step();
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_uf_err", underflow_err, 0);
    rst_n = 1'b1;
    step();

    // Streaming 0x0001..0x0008 with the sink always ready
    m_ready = 1'b1;
    base    = pops;
    base_uf = uf_cnt;
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      wr_data = W'(i);
      step();
    end
    wr_en = 1'b0;
    wait_pops(base + 8, 40, "t1_pops");
    chk("t1_rd_count", rd_count, 8);
    chk("t1_order", sb_err, 0);
    chk("t1_no_underflow", uf_cnt - base_uf, 0);
    chk("t1_drained", m_valid, 0);
    chk("t1_uf_err", underflow_err, 0);

    // Back-pressure: 4 words, sink stalled
    do_reset();
    base_rd = rden_cnt;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = W'(16'h0010 + i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t2_two_reads", rden_cnt - base_rd, 2);
    chk("t2_valid", m_valid, 1);
    chk("t2_head", m_data, 16'h0010);
    chk("t2_rd_en_blocked", fifo_rd_en, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t2_head_stable", m_data, 16'h0010);
    chk("t2_still_two_reads", rden_cnt - base_rd, 2);
    base    = pops;
    m_ready = 1'b1;
    wait_pops(base + 4, 30, "t2_pops");
    chk("t2_rd_count", rd_count, 4);
    chk("t2_order", sb_err, 0);

    // Single word: one read, no second read while the last word is in flight
    do_reset();
    base_rd = rden_cnt;
    base_uf = uf_cnt;
    wr_en   = 1'b1;
    wr_data = 16'h0055;
    step();
    wr_en = 1'b0;
    wait_rden(6, "t3_rd_issued");
    chk("t3_valid_n", m_valid, 0);
    step();
    chk("t3_guard", fifo_rd_en, 0);
    chk("t3_valid_n1", m_valid, 0);
    step();
    chk("t3_valid_n2", m_valid, 1);
    chk("t3_data", m_data, 16'h0055);
    for (int i = 0; i < 3; i++) step();
    chk("t3_one_read", rden_cnt - base_rd, 1);
    chk("t3_uf_err", underflow_err, 0);
    chk("t3_no_underflow", uf_cnt - base_uf, 0);

    // Underflow on an in-flight read, sticky flag, set beats clear
    do_reset();
    wr_en   = 1'b1;
    wr_data = 16'h0077;
    step();
    wr_en = 1'b0;
    wait_rden(6, "t4_rd_issued");
    step();
    force_uf = 1'b1;
    step();
    force_uf = 1'b0;
    chk("t4_err_set", underflow_err, 1);
    chk("t4_discard", m_valid, 0);
    step();
    step();
    chk("t4_err_sticky", underflow_err, 1);
    chk("t4_not_buffered", m_valid, 0);
    wr_en   = 1'b1;
    wr_data = 16'h0078;
    step();
    wr_en = 1'b0;
    wait_rden(6, "t4_rd2_issued");
    step();
    force_uf  = 1'b1;
    clear_err = 1'b1;
    step();
    force_uf  = 1'b0;
    clear_err = 1'b0;
    chk("t4_set_wins", underflow_err, 1);
    chk("t4_discard2", m_valid, 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t4_cleared", underflow_err, 0);

    // Asynchronous reset with a full buffer and a read in flight
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = W'(16'h0020 + i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_valid_full", m_valid, 1);
    chk("t5_head", m_data, 16'h0020);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t5_rd_count_pre", rd_count, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_data", m_data, 0);
    chk("t5_rst_rd_count", rd_count, 0);
    chk("t5_rst_uf_err", underflow_err, 0);
    chk("t5_rst_rd_en", fifo_rd_en, 0);
    step();
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    base    = pops;
    wr_en   = 1'b1;
    wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    k = 0;
    while (!m_valid && k < 8) begin
      step();
      k++;
    end
    chk("t5_post_valid", m_valid, 1);
    chk("t5_post_first", m_data, 16'hBEEF);
    wait_pops(base + 1, 10, "t5_post_pop");
    chk("t5_order", sb_err, 0);

    // 70000 pops: rd_count wraps to 70000 mod 65536
    do_reset();
    m_ready = 1'b1;
    base    = pops;
    base_uf = uf_cnt;
    for (int i = 0; i < 70000; i++) begin
      wr_en   = 1'b1;
      wr_data = W'(i);
      step();
    end
    wr_en = 1'b0;
    wait_pops(base + 70000, 50, "t6_pops");
    chk("t6_rd_count_wrap", rd_count, 16'd4464);
    chk("t6_order", sb_err, 0);
    chk("t6_uf_err", underflow_err, 0);
    chk("t6_no_underflow", uf_cnt - base_uf, 0);
    chk("t6_drained", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
